// File: rtl/vga_scan_gen.sv
// vga_scan_gen: raster initiator for the drawing objects.
// It scans the frame and publishes pxl_x/pxl_y to every object.
// It delays the raw sync/blank timing by the objects' pipeline latency.
// It then registers the final colour, sync and blank onto the VGA connector.
module vga_scan_gen #(
    parameter int          H_ACTIVE = 640,
    parameter int          H_FP     = 16,
    parameter int          H_SYNC   = 96,
    parameter int          H_BP     = 48,
    parameter int          V_ACTIVE = 480,
    parameter int          V_FP     = 10,
    parameter int          V_SYNC   = 2,
    parameter int          V_BP     = 33,
    parameter int          PIPE_LAT = 2,
    parameter logic [11:0] BG_RGB   = 12'h000,
    localparam int         H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int         V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int         X_W      = (H_TOT > 1) ? $clog2(H_TOT) : 1,
    localparam int         Y_W      = (V_TOT > 1) ? $clog2(V_TOT) : 1
) (
    input  logic           clk,
    input  logic           reset,
    output logic [X_W-1:0] pxl_x,
    output logic [Y_W-1:0] pxl_y,
    input  logic           obj_drawing,
    input  logic [3:0]     obj_r,
    input  logic [3:0]     obj_g,
    input  logic [3:0]     obj_b,
    output logic [3:0]     vga_r,
    output logic [3:0]     vga_g,
    output logic [3:0]     vga_b,
    output logic           vga_hs,
    output logic           vga_vs,
    output logic           vga_blank,
    output logic           frame_start,
    output logic [15:0]    frame_cnt
);

    logic [X_W-1:0]      h_cnt;
    logic [Y_W-1:0]      v_cnt;
    int                  h_int;
    int                  v_int;
    logic                h_last;
    logic                v_last;
    logic                act_raw;
    logic                hs_raw_n;
    logic                vs_raw_n;
    logic [PIPE_LAT-1:0] act_pipe;
    logic [PIPE_LAT-1:0] hs_pipe;
    logic [PIPE_LAT-1:0] vs_pipe;
    logic                act_d;
    logic [11:0]         pix_rgb;

    // Counters are compared as full ints so the sync window end cannot be truncated.
    assign h_int  = int'(h_cnt);
    assign v_int  = int'(v_cnt);
    assign h_last = (h_int == H_TOT - 1);
    assign v_last = (v_int == V_TOT - 1);

    // Raw, undelayed timing for the pixel currently being offered to the objects.
    assign act_raw  = (h_int < H_ACTIVE) && (v_int < V_ACTIVE);
    assign hs_raw_n = !((h_int >= H_ACTIVE + H_FP) && (h_int < H_ACTIVE + H_FP + H_SYNC));
    assign vs_raw_n = !((v_int >= V_ACTIVE + V_FP) && (v_int < V_ACTIVE + V_FP + V_SYNC));

    assign pxl_x = h_cnt;
    assign pxl_y = v_cnt;
    assign act_d = act_pipe[PIPE_LAT-1];

    // Column counter wraps each line and steps the line counter, which wraps each frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // Delay line whose last stage lines up with the objects' obj_* answer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            act_pipe <= '0;
            hs_pipe  <= '1;
            vs_pipe  <= '1;
        end else begin
            act_pipe[0] <= act_raw;
            hs_pipe[0]  <= hs_raw_n;
            vs_pipe[0]  <= vs_raw_n;
            for (int i = 1; i < PIPE_LAT; i++) begin
                act_pipe[i] <= act_pipe[i-1];
                hs_pipe[i]  <= hs_pipe[i-1];
                vs_pipe[i]  <= vs_pipe[i-1];
            end
        end
    end

    // Colour choice: object colour, background, or black outside the visible area.
    always_comb begin
        pix_rgb = 12'h000;
        if (act_d) begin
            pix_rgb = obj_drawing ? {obj_r, obj_g, obj_b} : BG_RGB;
        end
    end

    // Output register: colour, sync and blank all leave on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vga_r     <= 4'h0;
            vga_g     <= 4'h0;
            vga_b     <= 4'h0;
            vga_hs    <= 1'b1;
            vga_vs    <= 1'b1;
            vga_blank <= 1'b1;
        end else begin
            vga_r     <= pix_rgb[11:8];
            vga_g     <= pix_rgb[7:4];
            vga_b     <= pix_rgb[3:0];
            vga_hs    <= hs_pipe[PIPE_LAT-1];
            vga_vs    <= vs_pipe[PIPE_LAT-1];
            vga_blank <= !act_d;
        end
    end

    // Frame marker rises together with the (0,0) scan position; the first frame after reset is not counted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_start <= 1'b0;
            frame_cnt   <= 16'h0000;
        end else begin
            frame_start <= h_last && v_last;
            if (h_last && v_last) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_scan_gen.sv
// tb_vga_scan_gen: directed checks of vga_scan_gen.
// Three instances are used: default timing, a tiny frame, and a tiny frame with PIPE_LAT=5.
module tb_vga_scan_gen;

    localparam int D_XW = 10;
    localparam int D_YW = 10;
    localparam int S_XW = 4;
    localparam int S_YW = 4;
    localparam int S_HTOT = 16;
    localparam int S_VTOT = 10;

    typedef struct {
        int          x;
        int          y;
        logic        drawing;
        logic [11:0] rgb;
        logic [11:0] exp_rgb;
        logic        exp_blank;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    logic [D_XW-1:0] d_pxl_x;
    logic [D_YW-1:0] d_pxl_y;
    logic            d_obj_drawing;
    logic [11:0]     d_obj_rgb;
    logic [3:0]      d_vga_r, d_vga_g, d_vga_b;
    logic            d_vga_hs, d_vga_vs, d_vga_blank, d_frame_start;
    logic [15:0]     d_frame_cnt;

    logic [S_XW-1:0] s_pxl_x;
    logic [S_YW-1:0] s_pxl_y;
    logic            s_obj_drawing;
    logic [11:0]     s_obj_rgb;
    logic [3:0]      s_vga_r, s_vga_g, s_vga_b;
    logic            s_vga_hs, s_vga_vs, s_vga_blank, s_frame_start;
    logic [15:0]     s_frame_cnt;

    logic [S_XW-1:0] p_pxl_x;
    logic [S_YW-1:0] p_pxl_y;
    logic            p_obj_drawing;
    logic [11:0]     p_obj_rgb;
    logic [3:0]      p_vga_r, p_vga_g, p_vga_b;
    logic            p_vga_hs, p_vga_vs, p_vga_blank, p_frame_start;
    logic [15:0]     p_frame_cnt;

    always #5 clk = ~clk;

    vga_scan_gen u_def (
        .clk(clk), .reset(reset), .pxl_x(d_pxl_x), .pxl_y(d_pxl_y),
        .obj_drawing(d_obj_drawing), .obj_r(d_obj_rgb[11:8]), .obj_g(d_obj_rgb[7:4]), .obj_b(d_obj_rgb[3:0]),
        .vga_r(d_vga_r), .vga_g(d_vga_g), .vga_b(d_vga_b), .vga_hs(d_vga_hs), .vga_vs(d_vga_vs),
        .vga_blank(d_vga_blank), .frame_start(d_frame_start), .frame_cnt(d_frame_cnt)
    );

    vga_scan_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .PIPE_LAT(2), .BG_RGB(12'h123)
    ) u_sml (
        .clk(clk), .reset(reset), .pxl_x(s_pxl_x), .pxl_y(s_pxl_y),
        .obj_drawing(s_obj_drawing), .obj_r(s_obj_rgb[11:8]), .obj_g(s_obj_rgb[7:4]), .obj_b(s_obj_rgb[3:0]),
        .vga_r(s_vga_r), .vga_g(s_vga_g), .vga_b(s_vga_b), .vga_hs(s_vga_hs), .vga_vs(s_vga_vs),
        .vga_blank(s_vga_blank), .frame_start(s_frame_start), .frame_cnt(s_frame_cnt)
    );

    vga_scan_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .PIPE_LAT(5)
    ) u_lat5 (
        .clk(clk), .reset(reset), .pxl_x(p_pxl_x), .pxl_y(p_pxl_y),
        .obj_drawing(p_obj_drawing), .obj_r(p_obj_rgb[11:8]), .obj_g(p_obj_rgb[7:4]), .obj_b(p_obj_rgb[3:0]),
        .vga_r(p_vga_r), .vga_g(p_vga_g), .vga_b(p_vga_b), .vga_hs(p_vga_hs), .vga_vs(p_vga_vs),
        .vga_blank(p_vga_blank), .frame_start(p_frame_start), .frame_cnt(p_frame_cnt)
    );

    // Advance one clock and settle just after the edge, well away from the next one.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare one observed value against its expected value and record the result.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic int cur_x(input int inst);
        case (inst)
            0:       return int'(d_pxl_x);
            1:       return int'(s_pxl_x);
            default: return int'(p_pxl_x);
        endcase
    endfunction

    function automatic int cur_y(input int inst);
        case (inst)
            0:       return int'(d_pxl_y);
            1:       return int'(s_pxl_y);
            default: return int'(p_pxl_y);
        endcase
    endfunction

    // Step until the chosen instance presents (x,y), giving up after budget clocks.
    task automatic wait_pixel(input int inst, input int x, input int y, input int budget, input string name);
        int n = 0;
        while (!(cur_x(inst) == x && cur_y(inst) == y) && n < budget) begin
            tick();
            n++;
        end
        checkOutput(name, 32'((cur_x(inst) == x) && (cur_y(inst) == y)), 32'd1);
    endtask

    // Play the object for one table entry on the small instance, aligned PIPE_LAT=2 clocks after its pixel.
    task automatic applyStimulus(input vec_t v, input int idx);
        wait_pixel(1, v.x, v.y, 400, $sformatf("tbl%0d_reach", idx));
        repeat (2) tick();
        s_obj_drawing = v.drawing;
        s_obj_rgb     = v.rgb;
        tick();
        s_obj_drawing = 1'b0;
        s_obj_rgb     = 12'h000;
        checkOutput($sformatf("tbl%0d_rgb", idx), 32'({s_vga_r, s_vga_g, s_vga_b}), 32'(v.exp_rgb));
        checkOutput($sformatf("tbl%0d_blank", idx), 32'(s_vga_blank), 32'(v.exp_blank));
    endtask

    // Global time limit so the bench can never hang.
    initial begin
        #900000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main directed sequence.
    initial begin
        vec_t vecs[10];
        int   pulses;
        int   lows;
        int   errs;
        logic hs799;
        logic hs800;

        vecs[0] = '{0, 0, 1'b1, 12'hA5C, 12'hA5C, 1'b0};
        vecs[1] = '{4, 0, 1'b0, 12'hFFF, 12'h123, 1'b0};
        vecs[2] = '{7, 0, 1'b1, 12'h0F0, 12'h0F0, 1'b0};
        vecs[3] = '{12, 0, 1'b1, 12'hFFF, 12'h000, 1'b1};
        vecs[4] = '{15, 0, 1'b1, 12'hFFF, 12'h000, 1'b1};
        vecs[5] = '{8, 1, 1'b1, 12'hFFF, 12'h000, 1'b1};
        vecs[6] = '{5, 2, 1'b0, 12'hABC, 12'h123, 1'b0};
        vecs[7] = '{3, 5, 1'b1, 12'h00F, 12'h00F, 1'b0};
        vecs[8] = '{3, 6, 1'b1, 12'hFFF, 12'h000, 1'b1};
        vecs[9] = '{0, 9, 1'b0, 12'h000, 12'h000, 1'b1};

        reset = 1'b1;
        d_obj_drawing = 1'b0; d_obj_rgb = 12'h000;
        s_obj_drawing = 1'b0; s_obj_rgb = 12'h000;
        p_obj_drawing = 1'b0; p_obj_rgb = 12'h000;
        repeat (3) tick();

        checkOutput("rst_pxl_x", 32'(d_pxl_x), 32'd0);
        checkOutput("rst_blank", 32'(d_vga_blank), 32'd1);
        checkOutput("rst_hs", 32'(d_vga_hs), 32'd1);
        checkOutput("rst_vs", 32'(d_vga_vs), 32'd1);
        checkOutput("rst_rgb", 32'({d_vga_r, d_vga_g, d_vga_b}), 32'd0);
        checkOutput("rst_fstart", 32'(d_frame_start), 32'd0);
        checkOutput("rst_fcnt", 32'(d_frame_cnt), 32'd0);

        reset = 1'b0;
        wait_pixel(0, 300, 0, 400, "reach_x300");
        checkOutput("pre_rst_blank", 32'(d_vga_blank), 32'd0);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_pxl_x", 32'(d_pxl_x), 32'd0);
        checkOutput("async_blank", 32'(d_vga_blank), 32'd1);
        checkOutput("async_sml_rgb", 32'({s_vga_r, s_vga_g, s_vga_b}), 32'd0);
        checkOutput("async_sml_fcnt", 32'(s_frame_cnt), 32'd0);
        checkOutput("async_lat5_blank", 32'(p_vga_blank), 32'd1);
        #1 reset = 1'b0;

        pulses = 0;
        for (int i = 1; i <= 485; i++) begin
            tick();
            if (i <= 2) begin
                checkOutput($sformatf("rel_blank_%0d", i), 32'(d_vga_blank), 32'd1);
                checkOutput($sformatf("rel_pxl_x_%0d", i), 32'(d_pxl_x), 32'(i));
            end
            if (i == 3) checkOutput("rel_blank_3", 32'(d_vga_blank), 32'd0);
            if (i == 5) checkOutput("lat5_blank_5", 32'(p_vga_blank), 32'd1);
            if (i == 6) checkOutput("lat5_blank_6", 32'(p_vga_blank), 32'd0);
            if (s_frame_start) begin
                pulses++;
                checkOutput("fstart_time", 32'(i), 32'(S_HTOT * S_VTOT * pulses));
                checkOutput("fstart_cnt", 32'(s_frame_cnt), 32'(pulses));
                checkOutput("fstart_origin", 32'({s_pxl_x, s_pxl_y}), 32'd0);
            end
        end
        checkOutput("fstart_pulses", 32'(pulses), 32'd3);
        checkOutput("fcnt_final", 32'(s_frame_cnt), 32'd3);

        wait_pixel(0, 656, 0, 1000, "reach_x656");
        repeat (2) tick();
        checkOutput("hs_before_fall", 32'(d_vga_hs), 32'd1);
        tick();
        checkOutput("hs_fall_at_3", 32'(d_vga_hs), 32'd0);
        lows = 0;
        hs799 = 1'b0;
        hs800 = 1'b1;
        for (int i = 1; i <= 800; i++) begin
            tick();
            if (!d_vga_hs) lows++;
            if (i == 799) hs799 = d_vga_hs;
            if (i == 800) hs800 = d_vga_hs;
        end
        checkOutput("hs_low_count", 32'(lows), 32'd96);
        checkOutput("hs_799", 32'(hs799), 32'd1);
        checkOutput("hs_800", 32'(hs800), 32'd0);
        checkOutput("vs_line1", 32'(d_vga_vs), 32'd1);

        wait_pixel(0, 10, 20, 20000, "reach_10_20");
        repeat (2) tick();
        checkOutput("left_nb_rgb", 32'({d_vga_r, d_vga_g, d_vga_b}), 32'h000);
        checkOutput("left_nb_blank", 32'(d_vga_blank), 32'd0);
        d_obj_drawing = 1'b1;
        d_obj_rgb     = 12'hA5C;
        tick();
        d_obj_drawing = 1'b0;
        d_obj_rgb     = 12'h000;
        checkOutput("obj_rgb", 32'({d_vga_r, d_vga_g, d_vga_b}), 32'hA5C);
        checkOutput("obj_blank", 32'(d_vga_blank), 32'd0);
        tick();
        checkOutput("right_nb_rgb", 32'({d_vga_r, d_vga_g, d_vga_b}), 32'h000);
        checkOutput("right_nb_blank", 32'(d_vga_blank), 32'd0);

        wait_pixel(0, 640, 20, 800, "reach_640_20");
        repeat (2) tick();
        d_obj_drawing = 1'b1;
        d_obj_rgb     = 12'hFFF;
        errs = 0;
        for (int k = 0; k < 160; k++) begin
            tick();
            if ({d_vga_r, d_vga_g, d_vga_b} != 12'h000 || d_vga_blank != 1'b1) errs++;
        end
        d_obj_drawing = 1'b0;
        d_obj_rgb     = 12'h000;
        checkOutput("hblank_errors", 32'(errs), 32'd0);

        wait_pixel(1, 10, 1, 400, "sml_reach_hs");
        repeat (3) tick();
        checkOutput("sml_hs_low", 32'(s_vga_hs), 32'd0);
        wait_pixel(1, 13, 1, 400, "sml_reach_hs_end");
        repeat (3) tick();
        checkOutput("sml_hs_high", 32'(s_vga_hs), 32'd1);
        wait_pixel(1, 0, 7, 400, "sml_reach_vs");
        repeat (2) tick();
        checkOutput("sml_vs_before", 32'(s_vga_vs), 32'd1);
        tick();
        checkOutput("sml_vs_low", 32'(s_vga_vs), 32'd0);
        wait_pixel(1, 15, 8, 400, "sml_reach_vs_end");
        repeat (3) tick();
        checkOutput("sml_vs_last", 32'(s_vga_vs), 32'd0);
        wait_pixel(1, 0, 9, 400, "sml_reach_vs_after");
        repeat (3) tick();
        checkOutput("sml_vs_after", 32'(s_vga_vs), 32'd1);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i], i);
        end

        wait_pixel(2, 2, 1, 400, "lat5_reach_early");
        repeat (4) tick();
        p_obj_drawing = 1'b1;
        p_obj_rgb     = 12'hA5C;
        tick();
        p_obj_drawing = 1'b0;
        p_obj_rgb     = 12'h000;
        checkOutput("lat5_prev_pixel", 32'({p_vga_r, p_vga_g, p_vga_b}), 32'hA5C);
        tick();
        checkOutput("lat5_early_ignored", 32'({p_vga_r, p_vga_g, p_vga_b}), 32'h000);

        wait_pixel(2, 2, 2, 400, "lat5_reach_aligned");
        repeat (5) tick();
        p_obj_drawing = 1'b1;
        p_obj_rgb     = 12'hA5C;
        tick();
        p_obj_drawing = 1'b0;
        p_obj_rgb     = 12'h000;
        checkOutput("lat5_aligned_rgb", 32'({p_vga_r, p_vga_g, p_vga_b}), 32'hA5C);
        checkOutput("lat5_aligned_blank", 32'(p_vga_blank), 32'd0);
        tick();
        checkOutput("lat5_after_rgb", 32'({p_vga_r, p_vga_g, p_vga_b}), 32'h000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
